// File: rtl/uart_pkg.sv
// Shared UART definitions: launch-controller state encoding and the default byte width.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_fifo_state_t;

endpackage

// File: rtl/uart_fifo_ram.sv
// DEPTH x DATA_W register array: synchronous write, asynchronous read, contents never reset.
module uart_fifo_ram #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO plus launch controller for the UART serializer (start/busy/tx_done).
// Optional low-watermark interrupt (thresh/irq_low) when UART_TX_FIFO_THRESH_IRQ_EN is defined.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = UART_DATA_W,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       level,
  output logic              overflow,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_busy,
  input  logic              tx_done
`ifdef UART_TX_FIFO_THRESH_IRQ_EN
  ,
  input  logic [AW:0]       thresh,
  output logic              irq_low
`endif
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic [AW:0]       count_nxt;
  logic [DATA_W-1:0] rd_data;
  logic              push;
  logic              pop;
  tx_fifo_state_t    state;

  assign full  = (count == FULL_LVL);
  assign empty = (count == '0);
  assign level = count;

  // full comes from the registered count, so a push while full is dropped even if a pop coincides
  assign push = wr_en && !full && !clear;
  assign pop  = (state == IDLE) && !empty && !tx_busy;

  always_comb begin
    count_nxt = count;
    if (clear)              count_nxt = '0;
    else if (push && !pop)  count_nxt = count + 1'b1;
    else if (pop && !push)  count_nxt = count - 1'b1;
  end

  uart_fifo_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      count <= count_nxt;
      if (push)          wr_ptr   <= wr_ptr + 1'b1;
      if (pop)           rd_ptr   <= rd_ptr + 1'b1;
      if (wr_en && full) overflow <= 1'b1;
    end
  end

  // clear does not touch the FSM: an in-flight byte completes and tx_data holds
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            tx_data <= rd_data;
            state   <= START;
          end
        end
        START: begin
          tx_start <= 1'b1;
          state    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_done)      state <= IDLE;
          else if (tx_busy) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (tx_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_TX_FIFO_THRESH_IRQ_EN
  logic written;
  logic written_nxt;

  // written suppresses the interrupt at boot and after a flush until data is queued again
  assign written_nxt = !clear && (written || push);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      written <= 1'b0;
      irq_low <= 1'b0;
    end else begin
      written <= written_nxt;
      irq_low <= written_nxt && (count_nxt <= thresh);
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized self-checking bench for uart_tx_fifo against a queue-based reference model and a serializer model.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;

  logic       clk;
  logic       reset_n;
  logic       clear;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       overflow;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       ser_busy;
  logic       ser_done;
`ifdef UART_TX_FIFO_THRESH_IRQ_EN
  logic [4:0] thresh;
  logic       irq_low;
`endif

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (clear),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (ser_busy),
    .tx_done  (ser_done)
`ifdef UART_TX_FIFO_THRESH_IRQ_EN
    ,
    .thresh   (thresh),
    .irq_low  (irq_low)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_on = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Serializer model: len 0 finishes without ever showing busy, otherwise busy for ser_len cycles
  int   ser_len = 10;
  bit   ser_hold = 0;
  int   ser_cnt;
  bit   start_seen;
  logic [7:0] data_seen;
  logic [7:0] rx_log[$];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ser_busy <= 1'b0;
      ser_done <= 1'b0;
      ser_cnt  <= 0;
    end else begin
      ser_done <= 1'b0;
      if (ser_hold) begin
        ser_busy <= 1'b1;
      end else if (ser_cnt > 0) begin
        if (ser_cnt == 1) begin
          ser_busy <= 1'b0;
          ser_done <= 1'b1;
        end
        ser_cnt <= ser_cnt - 1;
      end else if (start_seen) begin
        rx_log.push_back(data_seen);
        if (ser_len == 0) ser_done <= 1'b1;
        else begin
          ser_busy <= 1'b1;
          ser_cnt  <= ser_len;
        end
      end else begin
        ser_busy <= 1'b0;
      end
    end
  end

  // Reference model: byte queue plus "one byte in flight" launch tracking
  logic [7:0] mq[$];
  bit   m_ovf, m_wr, m_fly, m_pend, m_start;
  logic [7:0] m_data;
  int   pre_sz;
  bit   pend_pre, fly_pre;
  int   last_push;
  int   done_edges[$];
  int   start_edges[$];

  always @(posedge clk) begin
    cyc++;
    if (!reset_n) begin
      mq.delete();
      m_ovf = 0; m_wr = 0; m_fly = 0; m_pend = 0; m_start = 0; m_data = 8'h00;
    end else begin
      if (wr_en) last_push = cyc;
      if (ser_done) done_edges.push_back(cyc);
      pre_sz   = mq.size();
      pend_pre = m_pend;
      fly_pre  = m_fly;
      m_start  = pend_pre;
      m_pend   = 0;
      if (fly_pre && !pend_pre && ser_done) m_fly = 0;
      if (!fly_pre && pre_sz > 0 && !ser_busy) begin
        m_data = mq.pop_front();
        m_fly  = 1;
        m_pend = 1;
      end
      if (clear) begin
        mq.delete();
        m_ovf = 0;
        m_wr  = 0;
      end else if (wr_en) begin
        if (pre_sz < DEPTH) begin
          mq.push_back(wr_data);
          m_wr = 1;
        end else begin
          m_ovf = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    start_seen = tx_start;
    data_seen  = tx_data;
    if (reset_n && chk_on) begin
      chk("level", level, mq.size());
      chk("empty", empty, mq.size() == 0);
      chk("full", full, mq.size() == DEPTH);
      chk("overflow", overflow, m_ovf);
      chk("tx_start", tx_start, m_start);
      chk("tx_data", tx_data, m_data);
      if (tx_start) begin
        start_edges.push_back(cyc);
        chk("start_while_busy", ser_busy, 1'b0);
      end
`ifdef UART_TX_FIFO_THRESH_IRQ_EN
      chk("irq_low", irq_low, m_wr && (mq.size() <= thresh));
`endif
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(logic [7:0] d);
    wr_en = 1'b1;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(string tag, int limit);
    int n = 0;
    while (!(mq.size() == 0 && !m_fly && !ser_busy && !ser_done) && n < limit) begin
      tick();
      n++;
    end
    if (n >= limit) chk({tag, "_timeout"}, 1, 0);
    tick(2);
  endtask

  task automatic clear_logs();
    rx_log.delete();
    start_edges.delete();
    done_edges.delete();
  endtask

  task automatic chk_log(string tag, logic [7:0] exp[$]);
    chk({tag, "_count"}, rx_log.size(), exp.size());
    for (int i = 0; i < exp.size() && i < rx_log.size(); i++)
      chk({tag, "_byte"}, rx_log[i], exp[i]);
  endtask

  logic [7:0] exp_q[$];
  logic [7:0] b;

  initial begin
    reset_n = 1'b1;
    clear = 1'b0;
    wr_en = 1'b0;
    wr_data = 8'h00;
`ifdef UART_TX_FIFO_THRESH_IRQ_EN
    thresh = 5'd2;
`endif
    #2 reset_n = 1'b0;
    tick(2);
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
`ifdef UART_TX_FIFO_THRESH_IRQ_EN
    chk("rst_irq_low", irq_low, 0);
`endif
    reset_n = 1'b1;
    chk_on = 1;
    tick(2);

    // Single byte: launch two edges after the push edge
    ser_len = 5;
    clear_logs();
    push(8'hA5);
    chk("single_level1", level, 1);
    tick();
    chk("single_level0", level, 0);
    wait_idle("single", 100);
    chk("single_starts", start_edges.size(), 1);
    if (start_edges.size() > 0) chk("single_latency", start_edges[0] - last_push, 2);
    exp_q = '{8'hA5};
    chk_log("single", exp_q);

    // Burst of four: each launch two edges after the previous tx_done
    ser_len = 10;
    clear_logs();
    for (int i = 1; i <= 4; i++) push(8'(i));
    wait_idle("burst", 300);
    chk("burst_starts", start_edges.size(), 4);
    for (int i = 1; i < 4 && i < start_edges.size() && i <= done_edges.size(); i++)
      chk("burst_gap", start_edges[i] - done_edges[i-1], 2);
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    chk_log("burst", exp_q);

    // Fill and overflow with the serializer held busy
    ser_len = 3;
    ser_hold = 1;
    tick(2);
    clear_logs();
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom_range(0, 254));
      exp_q.push_back(b);
      push(b);
    end
    chk("fill_full", full, 1);
    chk("fill_level", level, 16);
    push(8'hFF);
    chk("ovf_level", level, 16);
    chk("ovf_flag", overflow, 1);
    ser_hold = 0;
    wait_idle("fill", 400);
    chk_log("fill", exp_q);
    chk("ovf_sticky", overflow, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("ovf_cleared", overflow, 0);

    // Wrap-around: 40 bytes in groups of 7, varied serializer speed
    clear_logs();
    exp_q.delete();
    for (int g = 0; g < 6; g++) begin
      ser_len = $urandom_range(0, 6);
      for (int i = 0; i < 7 && exp_q.size() < 40; i++) begin
        b = 8'($urandom);
        exp_q.push_back(b);
        push(b);
        if ($urandom_range(0, 3) == 0) tick();
      end
      wait_idle("wrap", 200);
    end
    chk_log("wrap", exp_q);

    // Clear with a simultaneous write while byte 1 is in WAIT_DONE
    ser_len = 10;
    clear_logs();
    for (int i = 0; i < 5; i++) push(8'h30 + 8'(i));
    for (int n = 0; n < 20 && !ser_busy; n++) tick();
    chk("clr_busy_seen", ser_busy, 1);
    tick(2);
    clear = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'h77;
    tick();
    clear = 1'b0;
    wr_en = 1'b0;
    chk("clr_level", level, 0);
    chk("clr_overflow", overflow, 0);
`ifdef UART_TX_FIFO_THRESH_IRQ_EN
    chk("clr_irq_low", irq_low, 0);
`endif
    tick(30);
    chk("clr_starts", start_edges.size(), 1);
    exp_q = '{8'h30};
    chk_log("clr", exp_q);

    // Reset during a transfer
    clear_logs();
    push(8'h5A);
    push(8'h6B);
    for (int n = 0; n < 20 && !ser_busy; n++) tick();
    reset_n = 1'b0;
    #1;
    chk("mrst_tx_start", tx_start, 0);
    chk("mrst_level", level, 0);
    chk("mrst_tx_data", tx_data, 0);
    tick(2);
    reset_n = 1'b1;
    tick(15);
    chk("mrst_starts", start_edges.size(), 1);

`ifdef UART_TX_FIFO_THRESH_IRQ_EN
    // Low watermark: model checks every cycle; spot-check the key points
    thresh = 5'd2;
    chk("irq_after_reset", irq_low, 0);
    ser_hold = 1;
    tick(2);
    for (int i = 0; i < 4; i++) push(8'(8'hC0 + i));
    chk("irq_level4", irq_low, 0);
    ser_hold = 0;
    ser_len = 4;
    wait_idle("irq", 200);
    chk("irq_drained", irq_low, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("irq_after_clear", irq_low, 0);
    tick(3);
    chk("irq_still_low", irq_low, 0);
    push(8'h11);
    wait_idle("irq2", 100);
    chk("irq_after_push", irq_low, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
